d_branch_resolver: RTL and testbench
====================================

# d_branch_resolver

Parametrised successor to the decode-stage branch comparator. It resolves the six conditional branch types at D and adds a 2-bit saturating-counter predictor queried at F, in either bimodal or gshare mode. It also flags mispredictions and keeps branch and mispredict statistics. It sits between F (prediction lookup) and D (resolution, table update), driving NPC selection and F/D flush.

## Interface
- WIDTH, 32: operand width for comparisons.
- PHT_DEPTH, 64: pattern-history-table entries; power of two, at least 4; IDX_W = log2(PHT_DEPTH).
- GHR_W, 6: global history bits; must satisfy GHR_W ≤ IDX_W.
- MODE, 0: 0 = bimodal (index = f_pc[IDX_W+1:2]), 1 = gshare (index = f_pc[IDX_W+1:2] XOR zero-extended GHR).
- CNT_W, 32: statistics counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_pc  in  32  fetch PC.
- f_pred_taken  out  1  prediction, combinational from the PHT: counter MSB.
- f_pred_idx  out  IDX_W  PHT index used; pipelined externally to D.
- d_valid  in  1  D holds a real instruction.
- d_stall  in  1  D stalled; resolution outputs still valid, no state update.
- d_type  in  3  branch type (package constants).
- d_rs, d_rt  in  WIDTH  forwarded operands.
- d_pred_idx  in  IDX_W  index carried from F.
- d_pred_taken  in  1  prediction carried from F.
- d_b_jump  out  1  actual branch outcome.
- d_mispredict  out  1  d_valid & branch type & (d_b_jump ≠ d_pred_taken).
- branch_cnt  out  CNT_W  resolved branches.
- mispredict_cnt  out  CNT_W  resolved mispredictions.

## Operation
- Conditions:
  - B_BEQ: rs==rt.
  - B_BNE: rs!=rt.
  - B_BLEZ: $signed(rs)≤0.
  - B_BGTZ: $signed(rs)>0.
  - B_BLTZ: $signed(rs)<0.
  - B_BGEZ: $signed(rs)≥0.
- B_NONE (0), reserved code 7 and d_valid=0 all give d_b_jump=0 and d_mispredict=0. No latch; the output is fully assigned for every code.
- A commit happens in a cycle where d_valid & !d_stall & d_type∈{1..6}. On a commit:
  - PHT[d_pred_idx] increments if taken, saturating at 3; decrements if not taken, saturating at 0.
  - GHR becomes {GHR[GHR_W-2:0], d_b_jump}. The update is non-speculative.
  - branch_cnt increments by 1.
  - mispredict_cnt increments by 1 if d_mispredict.
  - Both counters saturate at all-ones and never wrap.
- A stalled D re-presents the same branch each cycle; only the final unstalled cycle commits, so each branch counts exactly once.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.

## Timing
- Resolution (d_b_jump, d_mispredict) is combinational: zero-cycle latency from D inputs.
- Prediction (f_pred_taken, f_pred_idx) is combinational from f_pc and current state.
- PHT, GHR and counter writes take effect at the edge ending the commit cycle and are visible to F the next cycle.
- Same-cycle F read and D write to the same index: F sees the old value (read-before-write).
- Reset values, applied asynchronously on reset low:
  - every PHT entry = 1 (weak-NT);
  - GHR = 0;
  - branch_cnt = mispredict_cnt = 0.
  - With the table at reset, f_pred_taken = 0 everywhere.
- Reset asserted mid-operation discards any pending commit. The first edge after reset deasserts may commit.

## Structure
- Shared constants file holds:
  - branch type codes B_NONE=0, B_BEQ=1, B_BNE=2, B_BLEZ=3, B_BGTZ=4, B_BLTZ=5, B_BGEZ=6;
  - counter encodings;
  - the reset counter value.
- One sub-module, `branch_cond`: pure combinational WIDTH-parametrised condition evaluator (type, rs, rt → taken). The top level holds the PHT array, GHR, update logic and statistics.

## Test plan
- Conditions: rs=0xFFFFFFFF, rt=0 with each type 1..6 → b_jump = 0,1,1,0,1,0; rs=rt=5 with BEQ → 1; type 7 → 0.
- Training: the same taken branch at pc=0x3000 in bimodal mode, committed 3 times → the entry goes 1→2→3→3; f_pred_taken=1 from the cycle after the first commit; d_mispredict=1 only on the first commit.
- Stall: d_stall=1 for 4 cycles, then 0 → exactly one counter update; branch_cnt rises by 1.
- gshare, GHR_W=2: commit T, T → GHR=2'b11; f_pc=0x3000 → f_pred_idx = pc[IDX_W+1:2] XOR 3.
- Collision: F reads and D writes index 5 in the same cycle → F returns the pre-update prediction; the next cycle returns the updated one.
- Reset mid-run after 10 commits: reset low asynchronously → counters 0, GHR 0, all f_pred_taken=0 before the next clock edge.

Source files
------------

// File: rtl/d_branch_resolver_pkg.sv
// Shared constants for the decode-stage branch resolver: branch type codes,
// 2-bit predictor counter encodings and the counter saturating-update helper.
package d_branch_resolver_pkg;

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CTR_W  = 2;

  typedef enum logic [TYPE_W-1:0] {
    B_NONE = 3'd0,
    B_BEQ  = 3'd1,
    B_BNE  = 3'd2,
    B_BLEZ = 3'd3,
    B_BGTZ = 3'd4,
    B_BLTZ = 3'd5,
    B_BGEZ = 3'd6,
    B_RSVD = 3'd7
  } br_type_e;

  typedef enum logic [CTR_W-1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  localparam logic [CTR_W-1:0] CTR_RESET = CTR_WNT;

  function automatic logic is_branch(input logic [TYPE_W-1:0] t);
    return (t != B_NONE) && (t != B_RSVD);
  endfunction

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c, input logic taken);
    if (taken) return (c == CTR_ST)  ? c : c + CTR_W'(1);
    else       return (c == CTR_SNT) ? c : c - CTR_W'(1);
  endfunction

endpackage

// File: rtl/d_branch_resolver_if.sv
// F-stage lookup and D-stage resolution signals between the pipeline and the
// branch resolver.
interface d_branch_resolver_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 32
);
  logic [31:0]       f_pc;
  logic              f_pred_taken;
  logic [IDX_W-1:0]  f_pred_idx;
  logic              d_valid;
  logic              d_stall;
  logic [2:0]        d_type;
  logic [WIDTH-1:0]  d_rs;
  logic [WIDTH-1:0]  d_rt;
  logic [IDX_W-1:0]  d_pred_idx;
  logic              d_pred_taken;
  logic              d_b_jump;
  logic              d_mispredict;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output f_pc, d_valid, d_stall, d_type, d_rs, d_rt, d_pred_idx, d_pred_taken,
    input  f_pred_taken, f_pred_idx, d_b_jump, d_mispredict, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  f_pc, d_valid, d_stall, d_type, d_rs, d_rt, d_pred_idx, d_pred_taken,
    output f_pred_taken, f_pred_idx, d_b_jump, d_mispredict, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/d_branch_resolver_branch_cond.sv
// Pure combinational condition evaluator for the six conditional branch types;
// none and reserved codes evaluate to not-taken.
module branch_cond
  import d_branch_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [TYPE_W-1:0] br_type,
  input  logic [WIDTH-1:0]  rs,
  input  logic [WIDTH-1:0]  rt,
  output logic              taken
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[WIDTH-1];
  assign rs_zero = (rs == '0);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      B_BEQ:   taken = (rs == rt);
      B_BNE:   taken = (rs != rt);
      B_BLEZ:  taken = rs_neg | rs_zero;
      B_BGTZ:  taken = ~rs_neg & ~rs_zero;
      B_BLTZ:  taken = rs_neg;
      B_BGEZ:  taken = ~rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_resolver.sv
// Decode-stage branch resolver with a 2-bit counter PHT (bimodal or gshare),
// non-speculative global history and saturating branch/mispredict statistics.
module d_branch_resolver
  import d_branch_resolver_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PHT_DEPTH = 64,
  parameter int unsigned GHR_W     = 6,
  parameter int unsigned MODE      = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  d_branch_resolver_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(PHT_DEPTH);

  logic [CTR_W-1:0] pht_q [PHT_DEPTH];
  logic [GHR_W-1:0] ghr_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic [IDX_W-1:0] f_idx;
  logic             cond_taken;
  logic             d_is_br;
  logic             b_jump;
  logic             mispredict;
  logic             commit;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{bus.f_pc[31:IDX_W+2], bus.f_pc[1:0]};

  // F-stage lookup; gshare folds zero-extended history into the PC index.
  always_comb begin
    f_idx = bus.f_pc[IDX_W+1:2];
    if (MODE != 0) f_idx = f_idx ^ IDX_W'(ghr_q);
  end

  assign bus.f_pred_idx   = f_idx;
  assign bus.f_pred_taken = pht_q[f_idx][CTR_W-1];

  branch_cond #(.WIDTH(WIDTH)) u_cond (
    .br_type (bus.d_type),
    .rs      (bus.d_rs),
    .rt      (bus.d_rt),
    .taken   (cond_taken)
  );

  assign d_is_br    = is_branch(bus.d_type);
  assign b_jump     = bus.d_valid & cond_taken;
  assign mispredict = bus.d_valid & d_is_br & (b_jump != bus.d_pred_taken);
  assign commit     = bus.d_valid & ~bus.d_stall & d_is_br;

  assign bus.d_b_jump       = b_jump;
  assign bus.d_mispredict   = mispredict;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

  // Table write lands at the end of the commit cycle, so F reads the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(PHT_DEPTH); i++) pht_q[i] <= CTR_RESET;
    end else if (commit) begin
      pht_q[bus.d_pred_idx] <= ctr_next(pht_q[bus.d_pred_idx], b_jump);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (commit) begin
      ghr_q <= GHR_W'({ghr_q, b_jump});
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (commit) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispredict && (mispredict_cnt_q != '1)) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_d_branch_resolver.sv
// Bench for d_branch_resolver: a bimodal instance and a 2-bit-history gshare
// instance with narrow statistics counters, checked against a behavioural model.
module tb_d_branch_resolver;

  localparam int NI = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  d_branch_resolver_if #(.WIDTH(32), .IDX_W(6), .CNT_W(32)) bif0();
  d_branch_resolver_if #(.WIDTH(32), .IDX_W(6), .CNT_W(3))  bif1();

  d_branch_resolver #(.WIDTH(32), .PHT_DEPTH(64), .GHR_W(6), .MODE(0), .CNT_W(32)) u_bim (
    .clk(clk), .reset(reset), .bus(bif0.slave)
  );

  d_branch_resolver #(.WIDTH(32), .PHT_DEPTH(64), .GHR_W(2), .MODE(1), .CNT_W(3)) u_gsh (
    .clk(clk), .reset(reset), .bus(bif1.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model state: counter value per entry, history as an integer, plain counts.
  int     pht  [NI][64];
  int     ghr  [NI];
  longint bcnt [NI];
  longint mcnt [NI];

  function automatic int gmask(input int k);
    return (k == 0) ? 63 : 3;
  endfunction

  function automatic longint cmax(input int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'd7;
  endfunction

  function automatic int m_idx(input int k, input logic [31:0] pc);
    int i;
    i = int'(pc[7:2]);
    if (k == 1) i = i ^ ghr[k];
    return i;
  endfunction

  function automatic bit m_isbr(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd6);
  endfunction

  function automatic bit m_cond(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
    int srs;
    srs = int'($signed(rs));
    case (t)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return srs <= 0;
      3'd4:    return srs > 0;
      3'd5:    return srs < 0;
      3'd6:    return srs >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 64; i++) pht[k][i] = 1;
      ghr[k]  = 0;
      bcnt[k] = 0;
      mcnt[k] = 0;
    end
  endfunction

  function automatic void m_commit(input int k, input int idx, input bit pt, input bit j);
    if (j && pht[k][idx] < 3) pht[k][idx] = pht[k][idx] + 1;
    if (!j && pht[k][idx] > 0) pht[k][idx] = pht[k][idx] - 1;
    ghr[k] = ((ghr[k] << 1) | int'(j)) & gmask(k);
    if (bcnt[k] < cmax(k)) bcnt[k] = bcnt[k] + 1;
    if ((j != pt) && (mcnt[k] < cmax(k))) mcnt[k] = mcnt[k] + 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int k, input logic [31:0] pc, input logic pt_out,
                          input logic [5:0] idx_out, input logic jump, input logic mis,
                          input logic [31:0] bc, input logic [31:0] mc, input logic pred_in,
                          input logic valid, input logic [2:0] t,
                          input logic [31:0] rs, input logic [31:0] rt);
    int ei;
    bit ej;
    bit em;
    ei = m_idx(k, pc);
    ej = valid && m_isbr(t) && m_cond(t, rs, rt);
    em = valid && m_isbr(t) && (ej != pred_in);
    chk($sformatf("i%0d f_pred_idx", k),     64'(idx_out), 64'(ei));
    chk($sformatf("i%0d f_pred_taken", k),   64'(pt_out),  64'(pht[k][ei] >= 2));
    chk($sformatf("i%0d d_b_jump", k),       64'(jump),    64'(ej));
    chk($sformatf("i%0d d_mispredict", k),   64'(mis),     64'(em));
    chk($sformatf("i%0d branch_cnt", k),     64'(bc),      64'(bcnt[k]));
    chk($sformatf("i%0d mispredict_cnt", k), 64'(mc),      64'(mcnt[k]));
  endtask

  always @(negedge reset) m_reset();

  // Model advances on the same edge as the DUT; reset low discards the commit.
  always @(posedge clk) begin
    if (reset && bif0.d_valid && !bif0.d_stall && m_isbr(bif0.d_type)) begin
      m_commit(0, int'(bif0.d_pred_idx), bif0.d_pred_taken, m_cond(bif0.d_type, bif0.d_rs, bif0.d_rt));
      m_commit(1, int'(bif1.d_pred_idx), bif1.d_pred_taken, m_cond(bif1.d_type, bif1.d_rs, bif1.d_rt));
    end
  end

  always @(negedge clk) begin
    chk_inst(0, bif0.f_pc, bif0.f_pred_taken, bif0.f_pred_idx, bif0.d_b_jump, bif0.d_mispredict,
             bif0.branch_cnt, bif0.mispredict_cnt, bif0.d_pred_taken, bif0.d_valid,
             bif0.d_type, bif0.d_rs, bif0.d_rt);
    chk_inst(1, bif1.f_pc, bif1.f_pred_taken, bif1.f_pred_idx, bif1.d_b_jump, bif1.d_mispredict,
             32'(bif1.branch_cnt), 32'(bif1.mispredict_cnt), bif1.d_pred_taken, bif1.d_valid,
             bif1.d_type, bif1.d_rs, bif1.d_rt);
  end

  // F and D see the same branch in one cycle; the carried prediction comes from the model.
  task automatic drive(input logic [31:0] pc, input logic v, input logic s, input logic [2:0] t,
                       input logic [31:0] rs, input logic [31:0] rt);
    bif0.f_pc = pc;          bif1.f_pc = pc;
    bif0.d_valid = v;        bif1.d_valid = v;
    bif0.d_stall = s;        bif1.d_stall = s;
    bif0.d_type = t;         bif1.d_type = t;
    bif0.d_rs = rs;          bif1.d_rs = rs;
    bif0.d_rt = rt;          bif1.d_rt = rt;
    bif0.d_pred_idx   = 6'(m_idx(0, pc));
    bif1.d_pred_idx   = 6'(m_idx(1, pc));
    bif0.d_pred_taken = (pht[0][m_idx(0, pc)] >= 2);
    bif1.d_pred_taken = (pht[1][m_idx(1, pc)] >= 2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    bif0.f_pc = pc;
    bif1.f_pc = pc;
  endtask

  bit cj [1:6];

  initial begin
    m_reset();
    cj = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    drive(32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #3;
    chk("reset branch_cnt", 64'(bif0.branch_cnt), 64'd0);
    chk("reset f_pred_taken", 64'(bif0.f_pred_taken), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Condition table with a negative rs, held in stall so nothing commits.
    for (int t = 1; t <= 6; t++) begin
      drive(32'h0, 1'b1, 1'b1, 3'(t), 32'hFFFF_FFFF, 32'h0);
      #2 chk($sformatf("cond type %0d", t), 64'(bif0.d_b_jump), 64'(cj[t]));
      step();
    end
    drive(32'h0, 1'b1, 1'b1, 3'd1, 32'd5, 32'd5);
    #2 chk("beq equal", 64'(bif0.d_b_jump), 64'd1);
    chk("beq equal mispredict", 64'(bif0.d_mispredict), 64'd1);
    step();
    drive(32'h0, 1'b1, 1'b0, 3'd7, 32'd5, 32'd5);
    #2 chk("type7 jump", 64'(bif0.d_b_jump), 64'd0);
    chk("type7 mispredict", 64'(bif0.d_mispredict), 64'd0);
    step();
    drive(32'h0, 1'b0, 1'b0, 3'd2, 32'd1, 32'd2);
    #2 chk("invalid jump", 64'(bif0.d_b_jump), 64'd0);
    step();
    chk("no commit yet", 64'(bif0.branch_cnt), 64'd0);

    // Train pc 0x3000 taken three times, then not-taken twice.
    drive(32'h3000, 1'b1, 1'b0, 3'd1, 32'd5, 32'd5);
    #2 chk("train1 pred", 64'(bif0.f_pred_taken), 64'd0);
    chk("train1 mispredict", 64'(bif0.d_mispredict), 64'd1);
    step();
    for (int n = 2; n <= 3; n++) begin
      drive(32'h3000, 1'b1, 1'b0, 3'd1, 32'd5, 32'd5);
      #2 chk($sformatf("train%0d pred", n), 64'(bif0.f_pred_taken), 64'd1);
      chk($sformatf("train%0d mispredict", n), 64'(bif0.d_mispredict), 64'd0);
      step();
    end
    drive(32'h3000, 1'b1, 1'b0, 3'd1, 32'd5, 32'd6);
    #2 chk("nt1 pred", 64'(bif0.f_pred_taken), 64'd1);
    step();
    drive(32'h3000, 1'b1, 1'b0, 3'd1, 32'd5, 32'd6);
    #2 chk("nt2 pred after saturation", 64'(bif0.f_pred_taken), 64'd1);
    step();
    drive(32'h3000, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2 chk("nt3 pred", 64'(bif0.f_pred_taken), 64'd0);
    step();

    // Two taken commits leave gshare history at 2'b11.
    repeat (2) begin
      drive(32'h3000, 1'b1, 1'b0, 3'd1, 32'd5, 32'd5);
      step();
    end
    drive(32'h3000, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2 chk("gshare idx", 64'(bif1.f_pred_idx), 64'd3);
    chk("bimodal idx", 64'(bif0.f_pred_idx), 64'd0);
    step();

    // Stalled branch counts once.
    repeat (4) begin
      drive(32'h40, 1'b1, 1'b1, 3'd2, 32'd1, 32'd2);
      step();
    end
    drive(32'h40, 1'b1, 1'b0, 3'd2, 32'd1, 32'd2);
    step();
    drive(32'h40, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2 chk("stall branch_cnt", 64'(bif0.branch_cnt), 64'd8);
    chk("stall mispredict_cnt", 64'(bif0.mispredict_cnt), 64'd5);
    chk("narrow cnt saturates", 64'(bif1.branch_cnt), 64'd7);
    chk("stall entry pred", 64'(bif0.f_pred_taken), 64'd1);
    step();
    drive(32'h40, 1'b1, 1'b0, 3'd2, 32'd3, 32'd3);
    step();
    drive(32'h40, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2 chk("stall single update", 64'(bif0.f_pred_taken), 64'd0);
    step();

    // Read and write of index 5 in one cycle.
    drive(32'h14, 1'b1, 1'b0, 3'd1, 32'd7, 32'd7);
    #2 chk("collision old pred", 64'(bif0.f_pred_taken), 64'd0);
    chk("collision idx", 64'(bif0.f_pred_idx), 64'd5);
    step();
    drive(32'h14, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2 chk("collision new pred", 64'(bif0.f_pred_taken), 64'd1);
    chk("ten commits", 64'(bif0.branch_cnt), 64'd10);
    step();

    // Asynchronous reset with a commit pending.
    drive(32'h3000, 1'b1, 1'b0, 3'd1, 32'd5, 32'd5);
    reset = 1'b0;
    #1 chk("async branch_cnt", 64'(bif0.branch_cnt), 64'd0);
    chk("async mispredict_cnt", 64'(bif0.mispredict_cnt), 64'd0);
    chk("async pred 3000", 64'(bif0.f_pred_taken), 64'd0);
    chk("async ghr idx", 64'(bif1.f_pred_idx), 64'd0);
    set_pc(32'h14);
    #1 chk("async pred 14", 64'(bif0.f_pred_taken), 64'd0);
    set_pc(32'h40);
    #1 chk("async pred 40", 64'(bif0.f_pred_taken), 64'd0);
    set_pc(32'h3000);
    step();
    chk("commit discarded", 64'(bif0.branch_cnt), 64'd0);
    reset = 1'b1;
    drive(32'h3000, 1'b1, 1'b0, 3'd1, 32'd5, 32'd5);
    step();
    drive(32'h3000, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2 chk("first commit after reset", 64'(bif0.branch_cnt), 64'd1);
    chk("pred after reset commit", 64'(bif0.f_pred_taken), 64'd1);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
